// File: rtl/l1_burst_responder.sv
// Word-addressed AXI-style L1 memory responder: INCR read bursts, optional write bursts, backdoor preload.
// Write channels exist only when L1_RESP_WRITE_EN is defined; otherwise the block is read-only.
module l1_burst_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_LEN    = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_ARVALID,
    output logic                  s_ARREADY,
    input  logic [31:0]           s_ARADDR,
    input  logic [7:0]            s_ARLEN,
    input  logic [2:0]            s_ARSIZE,
    output logic                  s_RVALID,
    input  logic                  s_RREADY,
    output logic [31:0]           s_RDATA,
    output logic                  s_RLAST,
    output logic                  s_RID,
    output logic [1:0]            s_RRESP,
    input  logic                  s_AWVALID,
    output logic                  s_AWREADY,
    input  logic [31:0]           s_AWADDR,
    input  logic [7:0]            s_AWLEN,
    input  logic [2:0]            s_AWSIZE,
    input  logic                  s_WVALID,
    output logic                  s_WREADY,
    input  logic [31:0]           s_WDATA,
    input  logic [3:0]            s_WSTRB,
    input  logic                  s_WLAST,
    output logic                  s_BVALID,
    input  logic                  s_BREADY,
    output logic [1:0]            s_BRESP,
    output logic                  s_BID,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [31:0]           init_data
);
    localparam int AW = DEPTH_LOG2;

    logic [31:0] mem [0:(1<<AW)-1];

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;

    // ---------------- read side ----------------
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    rstate_t     r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic        rerr_q, rerr_d;
    logic        rovf_q, rovf_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic        ar_bad;
    logic [31:0] rb_addr;
    logic        rb_ok;
    logic [32:0] rb_next;
    logic [31:0] rb_data;

    assign ar_bad = (s_ARSIZE != 3'b010) || (s_ARLEN > 8'(MAX_LEN));

    // One beat-load datapath shared by the first beat (from AR) and later beats (from the latched burst).
    always_comb begin
        rb_addr = (r_state_q == R_IDLE) ? s_ARADDR : raddr_q;
        rb_ok   = (r_state_q == R_IDLE) ? !ar_bad : !(rerr_q || rovf_q);
        rb_ok   = rb_ok && (rb_addr[31:AW+2] == '0);
        rb_next = {1'b0, rb_addr} + 33'd4;
        rb_data = rb_ok ? mem[rb_addr[AW+1:2]] : 32'd0;
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        rovf_d    = rovf_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && s_ARVALID) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rb_data;
                    rresp_d   = rb_ok ? 2'b00 : 2'b10;
                    rlast_d   = (s_ARLEN == 8'd0);
                    rcnt_d    = s_ARLEN;
                    raddr_d   = rb_next[31:0];
                    rovf_d    = rb_next[32];
                    rerr_d    = ar_bad;
                end
            end
            R_DATA: begin
                if (s_RREADY) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        rdata_d = rb_data;
                        rresp_d = rb_ok ? 2'b00 : 2'b10;
                        rlast_d = (rcnt_q == 8'd1);
                        rcnt_d  = rcnt_q - 8'd1;
                        raddr_d = rb_next[31:0];
                        // once the address wraps past 2^32 the rest of the burst stays out of range
                        rovf_d  = rovf_q | rb_next[32];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            rovf_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            rovf_q    <= rovf_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign s_ARREADY = arready_q;
    assign s_RVALID  = rvalid_q;
    assign s_RDATA   = rdata_q;
    assign s_RRESP   = rresp_q;
    assign s_RLAST   = rlast_q;
    assign s_RID     = 1'b0;

    // ---------------- write side ----------------
`ifdef L1_RESP_WRITE_EN
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    wstate_t     w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d;
    logic [8:0]  wbeat_q, wbeat_d;
    logic        werr_q, werr_d;
    logic        wovf_q, wovf_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        aw_bad, aw_hs, w_hs, wb_last_exp, wb_ok;
    logic [32:0] wb_next;

    assign s_AWREADY = awready_q & ~init_we;
    assign s_WREADY  = (w_state_q == W_DATA) & ~init_we;
    assign s_BVALID  = (w_state_q == W_RESP);
    assign s_BRESP   = bresp_q;
    assign s_BID     = 1'b0;

    assign aw_bad      = (s_AWSIZE != 3'b010) || (s_AWLEN > 8'(MAX_LEN));
    assign aw_hs       = s_AWVALID & s_AWREADY;
    assign w_hs        = s_WVALID & s_WREADY;
    assign wb_last_exp = (wbeat_q == {1'b0, wlen_q});
    // beats past the announced length are dropped, not written
    assign wb_ok       = !werr_q && !wovf_q && (waddr_q[31:AW+2] == '0) && (wbeat_q <= {1'b0, wlen_q});
    assign wb_next     = {1'b0, waddr_q} + 33'd4;

    assign mem_widx  = waddr_q[AW+1:2];
    assign mem_wdata = s_WDATA;
    assign mem_wstrb = s_WSTRB;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        wovf_d    = wovf_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    waddr_d   = s_AWADDR;
                    wlen_d    = s_AWLEN;
                    wbeat_d   = '0;
                    werr_d    = aw_bad;
                    wovf_d    = 1'b0;
                    bresp_d   = aw_bad ? 2'b10 : 2'b00;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    mem_we = wb_ok;
                    if (!wb_ok || (s_WLAST != wb_last_exp)) bresp_d = 2'b10;
                    if (s_WLAST) begin
                        w_state_d = W_RESP;
                    end else begin
                        wbeat_d = (&wbeat_q) ? wbeat_q : wbeat_q + 9'd1;
                        waddr_d = wb_next[31:0];
                        wovf_d  = wovf_q | wb_next[32];
                    end
                end
            end
            W_RESP: begin
                if (s_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            wovf_q    <= 1'b0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            wovf_q    <= wovf_d;
            bresp_q   <= bresp_d;
        end
    end

    logic unused_wbits;
    assign unused_wbits = ^{waddr_q[1:0], s_AWADDR[1:0]};
`else
    assign s_AWREADY = 1'b0;
    assign s_WREADY  = 1'b0;
    assign s_BVALID  = 1'b0;
    assign s_BRESP   = 2'b00;
    assign s_BID     = 1'b0;
    assign mem_we    = 1'b0;
    assign mem_widx  = '0;
    assign mem_wdata = '0;
    assign mem_wstrb = '0;

    logic unused_wbits;
    assign unused_wbits = ^{s_AWVALID, s_AWADDR, s_AWLEN, s_AWSIZE, s_WVALID,
                            s_WDATA, s_WSTRB, s_WLAST, s_BREADY};
`endif

    logic unused_rbits;
    assign unused_rbits = ^rb_addr[1:0];

    // Backdoor load wins; W beats cannot handshake while it is active.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

endmodule

// File: doc/l1_burst_responder.md
# l1_burst_responder

Word-addressed AXI-style memory responder serving the `m_axi_l1_V_*` master port of a task unit (enqueuer, calc, color workers). It accepts INCR read bursts (header fetch, up to 16 beats) and write bursts, answers with RDATA/RLAST and B responses, and exposes a backdoor load port so benches and bring-up logic can preload graph headers and arrays. It is the slave end of the unit's L1 port for unit-level simulation and small standalone configurations.

## Interface
- `DEPTH_LOG2`, 10: log2 of memory depth in 32-bit words.
- `MAX_LEN`, 15: largest accepted ARLEN/AWLEN; longer bursts return error.
- Reset is `rstn`, synchronous, active-low; clock is `clk`.
- `clk` in 1: clock.
- `rstn` in 1: synchronous active-low reset.
- `s_ARVALID` in 1, `s_ARREADY` out 1, `s_ARADDR` in 32, `s_ARLEN` in 8, `s_ARSIZE` in 3: read address channel.
- `s_RVALID` out 1, `s_RREADY` in 1, `s_RDATA` out 32, `s_RLAST` out 1, `s_RID` out 1, `s_RRESP` out 2: read data channel.
- `s_AWVALID` in 1, `s_AWREADY` out 1, `s_AWADDR` in 32, `s_AWLEN` in 8, `s_AWSIZE` in 3: write address channel.
- `s_WVALID` in 1, `s_WREADY` out 1, `s_WDATA` in 32, `s_WSTRB` in 4, `s_WLAST` in 1: write data channel.
- `s_BVALID` out 1, `s_BREADY` in 1, `s_BRESP` out 2, `s_BID` out 1: write response channel.
- `init_we` in 1, `init_addr` in DEPTH_LOG2, `init_data` in 32: backdoor word write.

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`. A beat is in range if `addr[31:DEPTH_LOG2+2] == 0`. Each beat adds 4 to the address (32-bit add, no wrap handling; an overflow makes the beat out of range).
- Read FSM: R_IDLE -> R_DATA on AR handshake. In R_IDLE, `s_ARREADY`=1. On acceptance, latch address and beats = ARLEN+1, then load beat 0 into the RDATA/RRESP/RLAST registers. In R_DATA, on `s_RVALID & s_RREADY`: if RLAST, go to R_IDLE; otherwise load the next beat. `s_RREADY` low holds all R outputs stable.
- Error rules: if ARSIZE != 3'b010 or ARLEN > MAX_LEN, every beat of the burst gets RRESP=2'b10 and RDATA=0, with the full ARLEN+1 beats still returned. An out-of-range beat gets RRESP=2'b10 and RDATA=0. Otherwise RRESP=0. `s_RID` is always 0.
- Write FSM: W_IDLE -> W_DATA on AW handshake, W_DATA -> W_RESP on the W handshake with WLAST, W_RESP -> W_IDLE on B handshake.
  - Bytes are written per WSTRB.
  - Error beats (bad AWSIZE, AWLEN > MAX_LEN, out of range) are not written, and BRESP=2'b10 is sticky for that burst.
  - A WLAST arriving before the expected beat count, or missing on the last beat, also sets BRESP=2'b10. The FSM leaves W_DATA on WLAST only.
  - `s_BID` is always 0.
- `init_we` writes `init_data` to word `init_addr` at the clock edge. While `init_we` is high, `s_AWREADY` and `s_WREADY` are forced to 0.
- Read and write run concurrently. If a read beat loads the same word that a W beat commits in that cycle, the read returns the old data.
- Memory contents are not reset.

## Timing
- Reset values: `s_ARREADY`=0 during reset and 1 in the first cycle after. `s_AWREADY`=0 during reset and 1 after. `s_RVALID`=0, `s_RLAST`=0, `s_RDATA`=0, `s_RRESP`=0, `s_WREADY`=0, `s_BVALID`=0, `s_BRESP`=0. All FSMs go to IDLE.
- AR handshake at cycle T gives the first RVALID at T+1. With RREADY held high, the burst delivers 1 beat per cycle, so an N-beat burst occupies T+1..T+N. The next AR can be accepted at T+N+1 (ARREADY=0 during R_DATA).
- AW handshake at T gives WREADY=1 from T+1. B is valid the cycle after the WLAST handshake and is held until BREADY.
- Reset mid-burst aborts the burst: no remaining R beats and no B response. Partial writes already committed remain.

## Configuration
- `L1_RESP_WRITE_EN`: when defined, the write FSM and W/B channels operate as specified.
- When undefined, the block is read-only: `s_AWREADY`=`s_WREADY`=`s_BVALID`=0 permanently, BRESP/BID are 0, and the memory is loaded only via `init_we`.

## Test plan
- Preload words 0..9 with 0x100+i. Send AR with addr 0, ARLEN 9 and RREADY high. Expect 10 beats at T+1..T+10, data 0x100..0x109, RLAST only on the 10th beat, RRESP 0.
- Same burst with RREADY toggled 1,0,0,1,...: every beat is held stable while RREADY=0, and the sequence is unchanged.
- Send AR with ARLEN 3 at word index 2^DEPTH_LOG2−2: beats 0-1 return valid data with RRESP 0, and beats 2-3 return RDATA 0 with RRESP 2'b10.
- Write 2 beats to addr 0x40 with WSTRB 4'b0011 and 4'b1111 over prior contents 0xFFFFFFFF: expect BRESP 0, and a readback of 0xFFFF_xxxx (low half written) and the full second word.
- Send AR with ARSIZE 3'b011 and ARLEN 1: expect 2 beats, both RRESP 2'b10 and data 0. Send AW with AWLEN 16: expect BRESP 2'b10 and memory unchanged.
- Assert rstn low in the middle of a read burst at beat 3 of 8: RVALID is 0 in the next cycle, ARREADY returns to 1 after reset, and a new burst completes normally.
